led_msg_player: RTL
===================

Name: led_msg_player

Overview:
- Parametrised successor to the fixed-text LED message sequencer.
- Plays a runtime-loadable message of LED_W-bit glyph codes from an internal DEPTH-entry buffer onto an LED bank, holding each glyph for TICK_CNT clocks.
- Supports one-shot and loop modes, pause and abort.
- Sits between the PS/register-write path (loads glyphs) and the board LED pins.

Parameters:
- LED_W, 7, glyph/LED width in bits.
- DEPTH, 64, message buffer entries; AW = $clog2(DEPTH).
- TICK_CNT, 25000000, clocks per glyph (500 ms at 50 MHz); must be >= 2.
- IDLE_PAT, all-zeros, LED pattern driven after a message ends or is aborted.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  buffer write strobe
- wr_addr  in  AW  buffer write address
- wr_data  in  LED_W  glyph written
- msg_len  in  AW+1  glyph count; sampled only when start is accepted
- loop  in  1  1 = repeat forever, 0 = one-shot; sampled at start
- start  in  1  start request, single-cycle or level
- pause  in  1  level; freezes playback while high
- stop  in  1  abort playback
- led  out  LED_W  LED drive
- busy  out  1  high from the cycle after start acceptance until playback ends
- done  out  1  one-cycle pulse when a one-shot message completes
- wrap  out  1  one-cycle pulse each time loop mode returns to glyph 0

Behaviour:
- Reset, synchronous, active-high, one clock:
  - led = all ones (lamp test); busy = 0, done = 0, wrap = 0.
  - state = IDLE; idx = 0; tick = 0.
  - Buffer contents are not reset.
- Buffer:
  - Written on any cycle with wr_en, in any state.
  - A write to the address currently displayed takes effect at the next glyph load; the current glyph is not changed.
- States: IDLE, SHOW, (GAP when the option is enabled), DONE.
- IDLE:
  - start=1 and msg_len!=0 and stop=0 → latch len = min(msg_len, DEPTH) and loop; idx = 0; tick = 0; go to SHOW.
  - msg_len=0 → start is ignored.
  - led keeps its previous value (all ones after reset, IDLE_PAT after a run).
- Start latency: with start accepted at cycle N, busy=1 and led=buf[0] at N+1.
- SHOW:
  - Each glyph is held exactly TICK_CNT non-paused cycles; tick counts 0..TICK_CNT-1.
  - On tick==TICK_CNT-1, advance:
    - idx<len-1 → idx+1, led=buf[idx+1] on the next cycle.
    - idx==len-1 and loop=1 → idx=0, wrap pulse, led=buf[0].
    - idx==len-1 and loop=0 → go to DONE.
- DONE: lasts one cycle. led=IDLE_PAT, done=1, busy=0 are registered as DONE is entered; next state is IDLE.
- pause=1: tick and idx hold; led held; busy stays 1; a pending advance is deferred. Pause in IDLE has no effect.
- stop=1 in SHOW/GAP: next cycle led=IDLE_PAT, busy=0, state=IDLE, no done, no wrap.
- Precedence: stop > pause > tick advance. start while busy is ignored. stop and start in the same cycle: stop wins, no start.
- len=1 loop: wrap pulses every TICK_CNT cycles, led constant.
- Reset mid-playback returns to the reset values in one cycle.
- Widths:
  - tick is $clog2(TICK_CNT) bits; idx is AW bits, len is AW+1 bits.
  - Comparisons are done at AW+1 width, so no wrap aliasing when DEPTH is a power of two.

Optional Feature:
- Macro LED_MSG_GAP_EN.
- Defined:
  - After each glyph's TICK_CNT cycles, enter GAP for TICK_CNT/4 cycles with led=IDLE_PAT, then load the next glyph.
  - Repeated glyphs ("pp") stay distinguishable.
  - No gap after the final glyph of a one-shot run.
  - pause and stop apply in GAP exactly as in SHOW.
- Undefined: the GAP state and its counter do not exist; glyphs are back-to-back.

Decomposition:
- Package led_msg_pkg holds:
  - the state enum (IDLE/SHOW/GAP/DONE);
  - glyph constants for the 7-bit ASCII-style codes (GLYPH_SPACE, GLYPH_A, ...);
  - a function clamping msg_len to DEPTH.
- One sub-module: led_msg_tick, a parametrised terminal-count divider with enable(!pause) and clear inputs and a one-cycle tc output; reused for the gap timer.

Test Plan (TICK_CNT=4, DEPTH=8, LED_W=7):
- Reset → led=7'h7F, busy=0, done=0. Write buf = {0x44,0x65,0x61}; msg_len=3, loop=0; pulse start at cycle N → led 0x44 at N+1..N+4, 0x65 at N+5..N+8, 0x61 at N+9..N+12; done=1 and led=0 at N+13; busy=0 at N+13.
- Same buffer, loop=1 → wrap pulses at N+13, N+25, N+37; led=0x44 at N+13; done never asserts.
- pause high for 5 cycles starting at N+2 → 0x44 is held 9 cycles total; all later transitions are shifted by 5.
- stop at N+6 with start also high → led=0, busy=0 at N+7, no done; a fresh start at N+10 restarts at buf[0].
- msg_len=0 start → busy stays 0. msg_len=12 (> DEPTH) → plays 8 glyphs. A write to buf[1] during glyph 0 → new value is shown at glyph 1.
- LED_MSG_GAP_EN with glyphs {0x70,0x70}: led 0x70 ×4, 0x00 ×1, 0x70 ×4, then done with no gap.

Source files
------------

// File: rtl/led_msg_pkg.sv
// led_msg_pkg: shared types and helpers for the LED message player.
//   state_e    - playback FSM states (StGap is used only with LED_MSG_GAP_EN)
//   GLYPH_*    - 7-bit ASCII-style glyph codes for building messages
//   clamp_len  - limits a requested message length to the buffer depth
package led_msg_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StShow,
      StGap,
      StDone
   } state_e;

   localparam logic [6:0] GLYPH_SPACE = 7'h20;
   localparam logic [6:0] GLYPH_A     = 7'h41;
   localparam logic [6:0] GLYPH_D     = 7'h44;
   localparam logic [6:0] GLYPH_E     = 7'h45;
   localparam logic [6:0] GLYPH_LC_A  = 7'h61;
   localparam logic [6:0] GLYPH_LC_E  = 7'h65;
   localparam logic [6:0] GLYPH_LC_P  = 7'h70;

   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
      return (len > depth) ? depth : len;
   endfunction

endpackage

// File: rtl/led_msg_tick.sv
// led_msg_tick: terminal-count divider.
// Counts enabled cycles 0..COUNT-1; tc is high (combinationally) on the enabled cycle
// in which the count is COUNT-1, and the counter wraps to 0 on that cycle.
// Ports:
//   clk - clock
//   rst - synchronous active-high reset
//   en  - count enable (held low while playback is paused)
//   clr - synchronous clear, overrides en
//   tc  - terminal-count pulse
module led_msg_tick #(
   parameter int unsigned COUNT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tc
);

   // Keep at least one bit so COUNT = 1 still elaborates (tc = en every cycle).
   localparam int unsigned CW = (COUNT > 1) ? $clog2(COUNT) : 1;
   localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

   logic [CW-1:0] cnt_q;

   assign tc = en && (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= tc ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/led_msg_player.sv
// led_msg_player: plays a runtime-loaded message of LED_W-bit glyphs onto an LED bank,
// holding each glyph for TICK_CNT clocks, in one-shot or loop mode, with pause and stop.
// Optional macro LED_MSG_GAP_EN: inserts a TICK_CNT/4-cycle blank (IDLE_PAT) between
// glyphs so repeated glyphs remain distinguishable; no gap after the final one-shot glyph.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   wr_en/addr/data   - message buffer write port (usable in any state)
//   msg_len, loop     - glyph count and repeat mode, sampled when start is accepted
//   start, pause, stop - playback control (stop > pause > advance)
//   led               - LED drive (all ones after reset)
//   busy, done, wrap  - playing, one-shot completion pulse, loop-restart pulse
module led_msg_player
   import led_msg_pkg::*;
#(
   parameter int unsigned      LED_W    = 7,
   parameter int unsigned      DEPTH    = 64,
   parameter int unsigned      TICK_CNT = 25000000,
   parameter logic [LED_W-1:0] IDLE_PAT = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [LED_W-1:0]         wr_data,
   input  logic [$clog2(DEPTH):0]   msg_len,
   input  logic                     loop,
   input  logic                     start,
   input  logic                     pause,
   input  logic                     stop,
   output logic [LED_W-1:0]         led,
   output logic                     busy,
   output logic                     done,
   output logic                     wrap
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [LED_W-1:0] mem [DEPTH];

   state_e           state_q, state_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic [LW-1:0]    len_q, len_d;
   logic             loop_q, loop_d;
   logic [LED_W-1:0] led_q, led_d;
   logic             wrap_q, wrap_d;

   logic             last;
   logic [AW-1:0]    nxt_idx;
   logic             tick_tc;

   // Buffer is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   led_msg_tick #(
      .COUNT (TICK_CNT)
   ) u_tick (
      .clk (clk),
      .rst (rst),
      .en  ((state_q == StShow) && !pause && !stop),
      .clr (state_q != StShow),
      .tc  (tick_tc)
   );

`ifdef LED_MSG_GAP_EN
   localparam int unsigned GAP_CNT = (TICK_CNT / 4 > 0) ? TICK_CNT / 4 : 1;

   logic gap_tc;

   led_msg_tick #(
      .COUNT (GAP_CNT)
   ) u_gap (
      .clk (clk),
      .rst (rst),
      .en  ((state_q == StGap) && !pause && !stop),
      .clr (state_q != StGap),
      .tc  (gap_tc)
   );
`endif

   // Compare at LW bits so idx = DEPTH-1 never aliases when DEPTH is a power of two.
   assign last    = ({1'b0, idx_q} == (len_q - 1'b1));
   assign nxt_idx = last ? '0 : idx_q + 1'b1;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      loop_d  = loop_q;
      led_d   = led_q;
      wrap_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start && !stop && (msg_len != '0)) begin
               state_d = StShow;
               idx_d   = '0;
               len_d   = LW'(clamp_len(32'(msg_len), DEPTH));
               loop_d  = loop;
               led_d   = mem[0];
            end
         end
         StShow: begin
            if (stop) begin
               state_d = StIdle;
               led_d   = IDLE_PAT;
            end else if (tick_tc) begin
               if (last && !loop_q) begin
                  state_d = StDone;
                  led_d   = IDLE_PAT;
               end else begin
`ifdef LED_MSG_GAP_EN
                  state_d = StGap;
                  led_d   = IDLE_PAT;
`else
                  idx_d   = nxt_idx;
                  led_d   = mem[nxt_idx];
                  wrap_d  = last;
`endif
               end
            end
         end
`ifdef LED_MSG_GAP_EN
         StGap: begin
            if (stop) begin
               state_d = StIdle;
               led_d   = IDLE_PAT;
            end else if (gap_tc) begin
               state_d = StShow;
               idx_d   = nxt_idx;
               led_d   = mem[nxt_idx];
               wrap_d  = last;
            end
         end
`endif
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         len_q   <= '0;
         loop_q  <= 1'b0;
         led_q   <= '1;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         loop_q  <= loop_d;
         led_q   <= led_d;
         wrap_q  <= wrap_d;
      end
   end

   assign led  = led_q;
   assign busy = (state_q == StShow) || (state_q == StGap);
   assign done = (state_q == StDone);
   assign wrap = wrap_q;

endmodule
